position_unit_sequencer: RTL and testbench
==========================================

Name: position_unit_sequencer

Overview:
- Controller that sequences the transform Position Unit (PU).
- Accepts a stream of input vertices and issues them one at a time on the PU cycle/ready/dataValid handshake.
- Holds PU inputs stable while a vertex is in flight and buffers the world/projected results in an output FIFO.
- Owns the position-matrix RAM; arbitrates between PU row reads and host matrix loads.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries (power of 2, ≥2).
- MAT_ROWS, 128, 128-bit rows in the position-matrix RAM (addressed by 7 bits).
- TIMEOUT, 255, max cycles in WAIT before the vertex is abandoned.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- vtx_valid  in  1  input vertex valid
- vtx_ready  out  1  input vertex accepted when valid&ready
- vtx_position  in  96  X[95:64] Y[63:32] Z[31:0], float32 each
- vtx_matidx  in  6  position-matrix index for the vertex
- pu_cycle  out  1  one-cycle start pulse to PU
- pu_ready  in  1  PU can start
- pu_data_valid  in  1  PU result valid (single-cycle pulse)
- pu_vin_position  out  96  held vertex to PU
- pu_vin_matrix  out  6  held matrix index to PU
- pu_world  in  96  PU world position
- pu_projected  in  128  PU projected position X,Y,Z,W
- pu_posmat_addr  in  7  PU matrix-row read address
- pu_posmat_enable  in  1  PU matrix-row read request
- pu_posmat_data  out  128  row data
- pu_posmat_valid  out  1  row data valid
- mat_wr_en  in  1  host matrix-row write request
- mat_wr_addr  in  7  row address
- mat_wr_data  in  128  row data
- mat_wr_ready  out  1  write accepted when en&ready
- out_valid  out  1  result FIFO head valid
- out_ready  in  1  consumer pop
- out_world  out  96  head world position
- out_projected  out  128  head projected position
- busy  out  1  state != IDLE
- vtx_count  out  16  vertices completed, wraps at 2^16
- timeout_err  out  1  sticky, set on WAIT timeout

Behaviour:

Reset (resetn low at posedge):
- State goes to IDLE.
- FIFO is emptied (pointers and count 0).
- vtx_count 0, timeout_err 0, pu_posmat_valid 0, hold registers 0.
- While resetn is low: vtx_ready=0, pu_cycle=0, mat_wr_ready=0, out_valid=0.
- RAM contents are retained across reset (undefined at power-up).
- Reset mid-operation abandons any in-flight vertex; a later pu_data_valid from that vertex is ignored because state is IDLE.

State machine, IDLE / ISSUE / WAIT:
- IDLE: vtx_ready = (fifo_count < FIFO_DEPTH).
  - On valid&ready, latch vtx_position and vtx_matidx into hold registers; next state is ISSUE.
- ISSUE: vtx_ready=0. pu_cycle = pu_ready, combinational.
  - If pu_ready: next state is WAIT and the timer is cleared.
  - Otherwise stay in ISSUE; there is no timeout in ISSUE.
- WAIT: timer increments each cycle.
  - On pu_data_valid: push {pu_world, pu_projected} into the FIFO, vtx_count+1, next state is IDLE.
  - Else if timer == TIMEOUT: timeout_err is set, no push, next state is IDLE.
- pu_data_valid outside WAIT is ignored.
- pu_vin_position and pu_vin_matrix hold their value from accept until the next accept.
- Latency: accept at cycle T, earliest pu_cycle at T+1, result out_valid on the cycle after pu_data_valid.
- Throughput: at most one vertex in flight.

Result FIFO:
- Registered output. out_valid = (count != 0); head data is driven from RAM/registers.
- A push is never lost: admission at IDLE guarantees a free slot, and pops only free slots.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Matrix RAM:
- Read: single port, 1-cycle latency. pu_posmat_data = ram[pu_posmat_addr] registered on enable; pu_posmat_valid is pu_posmat_enable delayed 1 cycle.
- Write: mat_wr_ready = (state == IDLE) & ~pu_posmat_enable.
  - Matrices cannot change under an in-flight vertex.
  - PU reads win same-cycle conflicts; a stalled write holds until ready.
- A write to a row and a read of the same row can never coincide, by the rule above.
- Addresses ≥ MAT_ROWS: write is dropped, read returns 0.

Test Plan:
1. Reset then idle: resetn low 2 cycles → vtx_ready=0, out_valid=0, vtx_count=0; after release vtx_ready=1, busy=0.
2. Single vertex, pu_ready=1, PU returns pu_data_valid 6 cycles after pu_cycle with world=0x3F800000_40000000_40400000 → pu_cycle exactly 1 cycle at T+1; out_valid next cycle with that world value; vtx_count=1.
3. Backpressure: FIFO_DEPTH=4, out_ready=0, 5 vertices offered → 4 complete, vtx_ready=0 in IDLE; one pop → 5th accepted and completes, count returns to 4.
4. Matrix arbitration: mat_wr_en held at row 3 while busy → mat_wr_ready=0 until IDLE. In IDLE with pu_posmat_enable asserted the same cycle → write stalls 1 cycle. A later read of row 3 returns the written data with valid 1 cycle after enable.
5. Timeout: pu_data_valid never asserted → after TIMEOUT=255 cycles in WAIT, timeout_err=1, state IDLE, vtx_count unchanged, no FIFO push.
6. Reset mid-WAIT, then stray pu_data_valid → no FIFO push, vtx_count stays 0.

Source files
------------

// File: rtl/position_unit_sequencer.sv
// Sequences single vertices through the Position Unit, buffers its results in a small FIFO
// and owns the position-matrix RAM shared between PU row reads and host row writes.
module position_unit_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAT_ROWS   = 128,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         vtx_valid,
    output logic         vtx_ready,
    input  logic [95:0]  vtx_position,
    input  logic [5:0]   vtx_matidx,
    output logic         pu_cycle,
    input  logic         pu_ready,
    input  logic         pu_data_valid,
    output logic [95:0]  pu_vin_position,
    output logic [5:0]   pu_vin_matrix,
    input  logic [95:0]  pu_world,
    input  logic [127:0] pu_projected,
    input  logic [6:0]   pu_posmat_addr,
    input  logic         pu_posmat_enable,
    output logic [127:0] pu_posmat_data,
    output logic         pu_posmat_valid,
    input  logic         mat_wr_en,
    input  logic [6:0]   mat_wr_addr,
    input  logic [127:0] mat_wr_data,
    output logic         mat_wr_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [95:0]  out_world,
    output logic [127:0] out_projected,
    output logic         busy,
    output logic [15:0]  vtx_count,
    output logic         timeout_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
    localparam logic [7:0]    ROWS_C    = 8'(MAT_ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [95:0]     pos_q, pos_d;
    logic [5:0]      mat_q, mat_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            terr_q, terr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic [127:0]    rd_data_q;

    logic [95:0]     fifo_world [FIFO_DEPTH];
    logic [127:0]    fifo_proj  [FIFO_DEPTH];
    logic [127:0]    ram        [MAT_ROWS];

    logic accept, push, pop, wr_fire, wr_in_range, rd_in_range;

    // Admission only from IDLE with a free slot, so a push from WAIT always finds room.
    assign vtx_ready    = resetn && (state_q == S_IDLE) && (fcnt_q < DEPTH_C);
    assign accept       = vtx_valid && vtx_ready;
    assign pu_cycle     = resetn && (state_q == S_ISSUE) && pu_ready;
    assign push         = resetn && (state_q == S_WAIT) && pu_data_valid;
    assign out_valid    = resetn && (fcnt_q != '0);
    assign pop          = out_valid && out_ready;
    assign mat_wr_ready = resetn && (state_q == S_IDLE) && !pu_posmat_enable;
    assign wr_fire      = mat_wr_en && mat_wr_ready;
    assign wr_in_range  = ({1'b0, mat_wr_addr} < ROWS_C);
    assign rd_in_range  = ({1'b0, pu_posmat_addr} < ROWS_C);

    assign pu_vin_position = pos_q;
    assign pu_vin_matrix   = mat_q;
    assign pu_posmat_data  = rd_data_q;
    assign pu_posmat_valid = rd_valid_q;
    assign out_world       = fifo_world[rd_ptr_q];
    assign out_projected   = fifo_proj[rd_ptr_q];
    assign busy            = (state_q != S_IDLE);
    assign vtx_count       = cnt_q;
    assign timeout_err     = terr_q;

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        mat_d      = mat_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        terr_d     = terr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fcnt_d     = fcnt_q;
        rd_valid_d = pu_posmat_enable;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pos_d   = vtx_position;
                    mat_d   = vtx_matidx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (pu_ready) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (pu_data_valid) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end else if (timer_q == TIMEOUT_C) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Depth is a power of two, so pointers wrap naturally.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            mat_q      <= '0;
            timer_q    <= '0;
            cnt_q      <= '0;
            terr_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            mat_q      <= mat_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_world[wr_ptr_q] <= pu_world;
            fifo_proj[wr_ptr_q]  <= pu_projected;
        end
    end

    // Storage arrays carry no reset so they map onto RAM; contents survive resetn.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_range)
            ram[mat_wr_addr] <= mat_wr_data;
        if (pu_posmat_enable)
            rd_data_q <= rd_in_range ? ram[pu_posmat_addr] : '0;
    end

endmodule

// File: tb/tb_position_unit_sequencer.sv
// Randomized self-checking bench for position_unit_sequencer with a queue-based result model.
module tb_position_unit_sequencer;

    logic         clk = 0;
    logic         resetn;
    logic         vtx_valid;
    logic         vtx_ready;
    logic [95:0]  vtx_position;
    logic [5:0]   vtx_matidx;
    logic         pu_cycle;
    logic         pu_ready;
    logic         pu_data_valid;
    logic [95:0]  pu_vin_position;
    logic [5:0]   pu_vin_matrix;
    logic [95:0]  pu_world;
    logic [127:0] pu_projected;
    logic [6:0]   pu_posmat_addr;
    logic         pu_posmat_enable;
    logic [127:0] pu_posmat_data;
    logic         pu_posmat_valid;
    logic         mat_wr_en;
    logic [6:0]   mat_wr_addr;
    logic [127:0] mat_wr_data;
    logic         mat_wr_ready;
    logic         out_valid;
    logic         out_ready;
    logic [95:0]  out_world;
    logic [127:0] out_projected;
    logic         busy;
    logic [15:0]  vtx_count;
    logic         timeout_err;

    localparam int DEPTH = 4;
    localparam int TMO   = 255;
    localparam int BOUND = 600;

    position_unit_sequencer #(.FIFO_DEPTH(DEPTH), .MAT_ROWS(128), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
        .vtx_position(vtx_position), .vtx_matidx(vtx_matidx),
        .pu_cycle(pu_cycle), .pu_ready(pu_ready), .pu_data_valid(pu_data_valid),
        .pu_vin_position(pu_vin_position), .pu_vin_matrix(pu_vin_matrix),
        .pu_world(pu_world), .pu_projected(pu_projected),
        .pu_posmat_addr(pu_posmat_addr), .pu_posmat_enable(pu_posmat_enable),
        .pu_posmat_data(pu_posmat_data), .pu_posmat_valid(pu_posmat_valid),
        .mat_wr_en(mat_wr_en), .mat_wr_addr(mat_wr_addr), .mat_wr_data(mat_wr_data),
        .mat_wr_ready(mat_wr_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_world(out_world), .out_projected(out_projected),
        .busy(busy), .vtx_count(vtx_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Reference model: results the PU has produced but the consumer has not yet popped.
    logic [223:0] exp_q[$];
    int           exp_count = 0;
    logic         exp_terr = 0;

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one vertex through accept / issue / wait; PU answers lat cycles after pu_cycle.
    task automatic run_vertex(input logic [95:0] pos, input logic [5:0] idx, input int lat,
                              input logic [95:0] w, input logic [127:0] p, output bit ok);
        int n;
        ok = 1;
        vtx_position = pos;
        vtx_matidx   = idx;
        vtx_valid    = 1;
        #1;
        n = 0;
        while (!vtx_ready && n < BOUND) begin tick(); n++; end
        if (!vtx_ready) begin ok = 0; vtx_valid = 0; return; end
        tick();
        vtx_valid = 0;
        n = 0;
        while (!pu_cycle && n < BOUND) begin tick(); n++; end
        if (!pu_cycle) begin ok = 0; return; end
        tick();
        repeat (lat - 1) tick();
        pu_world      = w;
        pu_projected  = p;
        pu_data_valid = 1;
        tick();
        pu_data_valid = 0;
        pu_world      = rnd96();
        pu_projected  = rnd128();
        exp_q.push_back({w, p});
        exp_count++;
    endtask

    task automatic test_reset();
        resetn = 0;
        vtx_valid = 1;
        mat_wr_en = 1;
        tick(); tick();
        total++; if (vtx_ready !== 1'b0) $display("FAIL reset_vtx_ready: got %b expected 0", vtx_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        total++; if (vtx_count !== 16'd0) $display("FAIL reset_vtx_count: got %0d expected 0", vtx_count); else passed++;
        total++; if (pu_cycle !== 1'b0 || mat_wr_ready !== 1'b0)
            $display("FAIL reset_handshakes: got pu_cycle=%b mat_wr_ready=%b expected 0 0", pu_cycle, mat_wr_ready); else passed++;
        resetn = 1;
        vtx_valid = 0;
        mat_wr_en = 0;
        tick();
        total++; if (vtx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL idle_after_reset: got ready=%b busy=%b expected 1 0", vtx_ready, busy); else passed++;
        total++; if (timeout_err !== 1'b0 || pu_posmat_valid !== 1'b0 || pu_vin_position !== 96'd0)
            $display("FAIL reset_regs: got terr=%b pmv=%b vin=%h expected 0 0 0", timeout_err, pu_posmat_valid, pu_vin_position); else passed++;
    endtask

    task automatic test_single();
        logic [95:0]  pos = rnd96();
        logic [5:0]   idx = 6'($urandom);
        logic [95:0]  w = 96'h3F800000_40000000_40400000;
        logic [127:0] p = rnd128();
        vtx_position = pos;
        vtx_matidx   = idx;
        vtx_valid    = 1;
        #1;
        total++; if (vtx_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", vtx_ready); else passed++;
        tick();
        vtx_valid    = 0;
        vtx_position = rnd96();
        #1;
        total++; if (pu_cycle !== 1'b1 || busy !== 1'b1)
            $display("FAIL single_pu_cycle_t1: got pu_cycle=%b busy=%b expected 1 1", pu_cycle, busy); else passed++;
        total++; if (pu_vin_position !== pos || pu_vin_matrix !== idx)
            $display("FAIL single_hold: got %h/%h expected %h/%h", pu_vin_position, pu_vin_matrix, pos, idx); else passed++;
        tick();
        total++; if (pu_cycle !== 1'b0) $display("FAIL single_pu_cycle_width: got %b expected 0", pu_cycle); else passed++;
        repeat (5) tick();
        pu_world = w; pu_projected = p; pu_data_valid = 1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL single_early_out: got %b expected 0", out_valid); else passed++;
        tick();
        pu_data_valid = 0;
        exp_count++;
        total++; if (out_valid !== 1'b1 || out_world !== w || out_projected !== p)
            $display("FAIL single_result: got v=%b %h %h expected 1 %h %h", out_valid, out_world, out_projected, w, p); else passed++;
        total++; if (vtx_count !== 16'(exp_count) || busy !== 1'b0)
            $display("FAIL single_count: got %0d busy=%b expected %0d 0", vtx_count, busy, exp_count); else passed++;
        total++; if (pu_vin_position !== pos) $display("FAIL single_hold_after: got %h expected %h", pu_vin_position, pos); else passed++;
        out_ready = 1;
        tick();
        out_ready = 0;
        total++; if (out_valid !== 1'b0) $display("FAIL single_pop: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic drain(input string tag);
        logic [223:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++; if (out_valid !== 1'b1 || {out_world, out_projected} !== e)
                $display("FAIL %s_drain: got v=%b %h expected 1 %h", tag, out_valid, {out_world, out_projected}, e); else passed++;
            out_ready = 1;
            tick();
            out_ready = 0;
        end
        total++; if (out_valid !== 1'b0) $display("FAIL %s_empty: got %b expected 0", tag, out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [95:0] pos5 = rnd96();
        logic [223:0] e;
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            run_vertex(rnd96(), 6'($urandom), int'($urandom_range(1, 8)), rnd96(), rnd128(), ok);
            total++; if (!ok) $display("FAIL bp_vertex%0d: got stalled expected completion", i); else passed++;
        end
        vtx_position = pos5;
        vtx_valid = 1;
        tick(); tick();
        total++; if (vtx_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_full: got ready=%b busy=%b expected 0 0", vtx_ready, busy); else passed++;
        e = exp_q.pop_front();
        total++; if ({out_world, out_projected} !== e) $display("FAIL bp_head: got %h expected %h", {out_world, out_projected}, e); else passed++;
        out_ready = 1;
        tick();
        out_ready = 0;
        run_vertex(pos5, 6'd9, 3, rnd96(), rnd128(), ok);
        total++; if (!ok) $display("FAIL bp_fifth: got stalled expected completion"); else passed++;
        vtx_valid = 1;
        #1;
        total++; if (vtx_ready !== 1'b0 || vtx_count !== 16'(exp_count))
            $display("FAIL bp_refull: got ready=%b cnt=%0d expected 0 %0d", vtx_ready, vtx_count, exp_count); else passed++;
        vtx_valid = 0;
        drain("bp");
    endtask

    task automatic test_matrix();
        logic [127:0] d0 = rnd128();
        logic [127:0] d1 = rnd128();
        logic [127:0] mdl [8];
        mat_wr_en = 1; mat_wr_addr = 7'd3; mat_wr_data = d0;
        #1;
        total++; if (mat_wr_ready !== 1'b1) $display("FAIL mat_idle_ready: got %b expected 1", mat_wr_ready); else passed++;
        tick();
        mat_wr_en = 0;
        pu_posmat_enable = 1; pu_posmat_addr = 7'd3;
        tick();
        pu_posmat_enable = 0;
        total++; if (pu_posmat_valid !== 1'b1 || pu_posmat_data !== d0)
            $display("FAIL mat_read_d0: got v=%b %h expected 1 %h", pu_posmat_valid, pu_posmat_data, d0); else passed++;
        // Vertex parked in ISSUE, then WAIT, with a write pending throughout.
        pu_ready = 0;
        vtx_valid = 1;
        tick();
        vtx_valid = 0;
        mat_wr_en = 1; mat_wr_data = d1;
        tick(); tick();
        total++; if (mat_wr_ready !== 1'b0 || busy !== 1'b1 || pu_posmat_valid !== 1'b0)
            $display("FAIL mat_busy_issue: got rdy=%b busy=%b pmv=%b expected 0 1 0", mat_wr_ready, busy, pu_posmat_valid); else passed++;
        pu_ready = 1;
        tick();
        tick();
        total++; if (mat_wr_ready !== 1'b0) $display("FAIL mat_busy_wait: got %b expected 0", mat_wr_ready); else passed++;
        pu_world = rnd96(); pu_projected = rnd128(); pu_data_valid = 1;
        exp_q.push_back({pu_world, pu_projected});
        exp_count++;
        pu_posmat_enable = 1; pu_posmat_addr = 7'd5;
        tick();
        pu_data_valid = 0;
        total++; if (mat_wr_ready !== 1'b0) $display("FAIL mat_read_wins: got %b expected 0", mat_wr_ready); else passed++;
        tick();
        pu_posmat_enable = 0;
        #1;
        total++; if (mat_wr_ready !== 1'b1 || pu_posmat_valid !== 1'b1)
            $display("FAIL mat_stall_release: got rdy=%b pmv=%b expected 1 1", mat_wr_ready, pu_posmat_valid); else passed++;
        tick();
        mat_wr_en = 0;
        pu_posmat_enable = 1; pu_posmat_addr = 7'd3;
        tick();
        pu_posmat_enable = 0;
        total++; if (pu_posmat_valid !== 1'b1 || pu_posmat_data !== d1)
            $display("FAIL mat_read_d1: got v=%b %h expected 1 %h", pu_posmat_valid, pu_posmat_data, d1); else passed++;
        tick();
        total++; if (pu_posmat_valid !== 1'b0) $display("FAIL mat_valid_drop: got %b expected 0", pu_posmat_valid); else passed++;
        // Random rows 64..71 written then read back in random order.
        for (int i = 0; i < 8; i++) begin
            mdl[i] = rnd128();
            mat_wr_en = 1; mat_wr_addr = 7'(64 + i); mat_wr_data = mdl[i];
            tick();
        end
        mat_wr_en = 0;
        for (int k = 0; k < 8; k++) begin
            int r = int'($urandom_range(0, 7));
            pu_posmat_enable = 1; pu_posmat_addr = 7'(64 + r);
            tick();
            pu_posmat_enable = 0;
            total++; if (pu_posmat_data !== mdl[r]) $display("FAIL mat_rand_row%0d: got %h expected %h", 64 + r, pu_posmat_data, mdl[r]); else passed++;
        end
        drain("mat");
    endtask

    task automatic test_timeout();
        int n;
        vtx_position = rnd96();
        vtx_valid = 1;
        tick();
        vtx_valid = 0;
        total++; if (pu_cycle !== 1'b1) $display("FAIL tmo_issue: got %b expected 1", pu_cycle); else passed++;
        tick();
        n = 0;
        while (busy && n < BOUND) begin tick(); n++; end
        exp_terr = 1;
        total++; if (n !== TMO + 1) $display("FAIL tmo_cycles: got %0d expected %0d", n, TMO + 1); else passed++;
        total++; if (timeout_err !== exp_terr || vtx_count !== 16'(exp_count) || out_valid !== 1'b0)
            $display("FAIL tmo_state: got terr=%b cnt=%0d ov=%b expected 1 %0d 0", timeout_err, vtx_count, out_valid, exp_count); else passed++;
        pu_data_valid = 1;
        tick();
        pu_data_valid = 0;
        total++; if (out_valid !== 1'b0 || vtx_count !== 16'(exp_count))
            $display("FAIL tmo_stray: got ov=%b cnt=%0d expected 0 %0d", out_valid, vtx_count, exp_count); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        vtx_valid = 1;
        tick();
        vtx_valid = 0;
        tick();
        tick();
        resetn = 0;
        tick();
        resetn = 1;
        exp_q.delete();
        exp_count = 0;
        exp_terr = 0;
        pu_world = rnd96(); pu_data_valid = 1;
        tick();
        pu_data_valid = 0;
        tick();
        total++; if (out_valid !== 1'b0 || vtx_count !== 16'(exp_count) || busy !== 1'b0)
            $display("FAIL rst_wait: got ov=%b cnt=%0d busy=%b expected 0 0 0", out_valid, vtx_count, busy); else passed++;
        total++; if (timeout_err !== exp_terr) $display("FAIL rst_terr: got %b expected %b", timeout_err, exp_terr); else passed++;
    endtask

    task automatic test_random();
        bit ok;
        logic [223:0] e;
        for (int i = 0; i < 20; i++) begin
            logic [95:0] pos = rnd96();
            logic [5:0]  idx = 6'($urandom);
            run_vertex(pos, idx, int'($urandom_range(1, 10)), rnd96(), rnd128(), ok);
            total++; if (!ok || pu_vin_position !== pos || pu_vin_matrix !== idx)
                $display("FAIL rand_vertex%0d: got ok=%0d vin=%h/%h expected 1 %h/%h", i, ok, pu_vin_position, pu_vin_matrix, pos, idx); else passed++;
            if (exp_q.size() == DEPTH || $urandom_range(0, 1) == 1) begin
                e = exp_q.pop_front();
                total++; if (out_valid !== 1'b1 || {out_world, out_projected} !== e)
                    $display("FAIL rand_pop%0d: got v=%b %h expected 1 %h", i, out_valid, {out_world, out_projected}, e); else passed++;
                out_ready = 1;
                tick();
                out_ready = 0;
            end
        end
        total++; if (vtx_count !== 16'(exp_count) || timeout_err !== exp_terr)
            $display("FAIL rand_count: got %0d terr=%b expected %0d %b", vtx_count, timeout_err, exp_count, exp_terr); else passed++;
        drain("rand");
    endtask

    initial begin
        resetn = 0; vtx_valid = 0; vtx_position = '0; vtx_matidx = '0;
        pu_ready = 1; pu_data_valid = 0; pu_world = '0; pu_projected = '0;
        pu_posmat_addr = '0; pu_posmat_enable = 0;
        mat_wr_en = 0; mat_wr_addr = '0; mat_wr_data = '0; out_ready = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_matrix();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
